// File: rtl/ip_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ip_stats_pkg
//  Description : Shared types, constants and helpers for the stats rate sampler
//  Revision    : 1.0 - initial release
// ============================================================================
package ip_stats_pkg;

  // Sampler control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // A window length of 0 is clamped up to this value
  localparam int unsigned MIN_WINDOW = 1;

  // Widest counter the delta helper supports
  localparam int unsigned DELTA_MAX_WIDTH = 64;

  // Modular subtraction; callers truncate the result to their counter width,
  // which makes a single counter wrap produce the correct delta.
  function automatic logic [DELTA_MAX_WIDTH-1:0] wrapDelta(
    input logic [DELTA_MAX_WIDTH-1:0] cur,
    input logic [DELTA_MAX_WIDTH-1:0] base
  );
    return cur - base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_stats_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ip_stats_window_timer
//  Description : Window down-counter with reload, 0->1 length clamp and a
//                window-end pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_stats_window_timer
  import ip_stats_pkg::*;
#(
  parameter int WIN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 run,
  input  logic [WIN_WIDTH-1:0] windowLen,
  output logic                 win_end
);

  logic [WIN_WIDTH-1:0] win_cnt_q;
  logic [WIN_WIDTH-1:0] win_cnt_d;
  logic [WIN_WIDTH-1:0] len_w;
  logic [WIN_WIDTH-1:0] reload_w;

  // Reload value: current window length (0 treated as 1) minus one
  always_comb begin
    len_w    = (windowLen == '0) ? WIN_WIDTH'(MIN_WINDOW) : windowLen;
    reload_w = len_w - WIN_WIDTH'(1);
  end

  assign win_end = run && (win_cnt_q == '0);

  // Load on arm or window end, otherwise count down while running
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (arm || win_end) begin
      win_cnt_d = reload_w;
    end else if (run) begin
      win_cnt_d = win_cnt_q - WIN_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_stats_rate_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ip_stats_rate_sampler
//  Description : Windowed wrap-safe rate sampler with peak tracking, overrun
//                flag and valid/ready delta output
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_stats_rate_sampler
  import ip_stats_pkg::*;
#(
  parameter int STATS_WIDTH = 8,
  parameter int WIN_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIN_WIDTH-1:0]   windowLen,
  input  logic [STATS_WIDTH-1:0] stats,
  input  logic                   clear,
  output logic                   rateValid,
  input  logic                   rateReady,
  output logic [STATS_WIDTH-1:0] rateDelta,
  output logic [STATS_WIDTH-1:0] rateMax,
  output logic                   overrun
);

  state_t                   state_q, state_d;
  logic [STATS_WIDTH-1:0]   base_q, base_d;
  logic                     valid_q, valid_d;
  logic [STATS_WIDTH-1:0]   delta_q, delta_d;
  logic [STATS_WIDTH-1:0]   max_q, max_d;
  logic                     ovr_q, ovr_d;

  logic                     win_end_w;
  logic [STATS_WIDTH-1:0]   sample_w;
  logic                     accept_w;
  logic                     load_w;
  logic                     drop_w;

  ip_stats_window_timer #(
    .WIN_WIDTH (WIN_WIDTH)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .arm       (state_q == ST_ARM),
    .run       (state_q == ST_RUN),
    .windowLen (windowLen),
    .win_end   (win_end_w)
  );

  assign sample_w = STATS_WIDTH'(wrapDelta(DELTA_MAX_WIDTH'(stats), DELTA_MAX_WIDTH'(base_q)));
  assign accept_w = valid_q && rateReady;
  // A window-end sample fits if the slot is empty or is being freed this edge
  assign load_w   = win_end_w && (!valid_q || accept_w);
  assign drop_w   = win_end_w && !load_w;

  // Next-state logic: IDLE -> ARM -> RUN, back to IDLE when enable drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: baseline, output slot, peak and overrun flag
  always_comb begin
    base_d  = base_q;
    valid_d = valid_q;
    delta_d = delta_q;
    max_d   = max_q;
    ovr_d   = ovr_q;

    if ((state_q == ST_ARM) || win_end_w) begin
      base_d = stats;
    end

    if (load_w) begin
      valid_d = 1'b1;
      delta_d = sample_w;
    end else if (accept_w) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      max_d = win_end_w ? sample_w : '0;
    end else if (win_end_w && (sample_w > max_q)) begin
      max_d = sample_w;
    end

    if (drop_w) begin
      ovr_d = 1'b1;
    end else if (clear) begin
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      valid_q <= 1'b0;
      delta_q <= '0;
      max_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      delta_q <= delta_d;
      max_q   <= max_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rateValid = valid_q;
  assign rateDelta = delta_q;
  assign rateMax   = max_q;
  assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_stats_rate_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_stats_rate_sampler
//  Description : Scoreboard bench for ip_stats_rate_sampler with an
//                edge-count reference model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_stats_rate_sampler;

  localparam int SW = 8;
  localparam int WW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [WW-1:0] windowLen = '0;
  logic [SW-1:0] stats = '0;
  logic          clear = 1'b0;
  logic          rateReady = 1'b0;
  logic          rateValid;
  logic [SW-1:0] rateDelta;
  logic [SW-1:0] rateMax;
  logic          overrun;

  ip_stats_rate_sampler #(.STATS_WIDTH(SW), .WIN_WIDTH(WW)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .windowLen (windowLen),
    .stats     (stats),
    .clear     (clear),
    .rateValid (rateValid),
    .rateReady (rateReady),
    .rateDelta (rateDelta),
    .rateMax   (rateMax),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 armed, 2 running. Window ends are tracked as absolute
  // edge numbers rather than a countdown.
  int edge_no = 0;
  int m_phase = 0;
  int m_next_end = 0;
  int m_base = 0;
  int m_valid = 0;
  int m_max = 0;
  int m_ovr = 0;
  int exp_q[$];
  int w_now, d, acc, ld, dr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_base = 0; m_valid = 0; m_max = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      edge_no++;
      w_now = (windowLen == 0) ? 1 : int'(windowLen);
      acc = (m_valid != 0 && rateReady) ? 1 : 0;
      if (m_phase == 2 && edge_no == m_next_end) begin
        d  = (int'(stats) - m_base + 256) % 256;
        ld = (m_valid == 0 || acc == 1) ? 1 : 0;
        dr = 1 - ld;
        if (ld == 1) begin
          exp_q.push_back(d);
          m_valid = 1;
        end
        if (clear) m_max = d;
        else if (d > m_max) m_max = d;
        if (dr == 1) m_ovr = 1;
        else if (clear) m_ovr = 0;
        m_base = int'(stats);
        m_next_end = edge_no + w_now;
      end else begin
        if (acc == 1) m_valid = 0;
        if (clear) begin
          m_max = 0;
          m_ovr = 0;
        end
      end
      case (m_phase)
        0: if (enable) m_phase = 1;
        1: begin
          m_base = int'(stats);
          m_next_end = edge_no + w_now;
          m_phase = 2;
        end
        default: if (!enable) m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    chk("rateValid", int'(rateValid), m_valid);
    chk("rateMax", int'(rateMax), m_max);
    chk("overrun", int'(overrun), m_ovr);
    if (rateValid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rateDelta: got %0d with no expected sample at %0t", rateDelta, $time);
      end else begin
        chk("rateDelta", int'(rateDelta), exp_q[0]);
        if (rateReady) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit en, input int wl, input bit rdy, input bit clr, input int inc);
    @(posedge clock);
    #1;
    enable    = en;
    windowLen = WW'(wl);
    rateReady = rdy;
    clear     = clr;
    stats     = stats + SW'(inc);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset rateValid", int'(rateValid), 0);
    chk("reset rateDelta", int'(rateDelta), 0);
    chk("reset rateMax", int'(rateMax), 0);
    chk("reset overrun", int'(overrun), 0);
    reset = 1'b1;

    // Basic: W=4, +1 per cycle, always ready
    repeat (40) drive(1, 4, 1, 0, 1);
    repeat (3) drive(0, 4, 1, 0, 1);

    // Wrap-around: baseline near the top of the counter range
    stats = 8'd247;
    repeat (30) drive(1, 4, 1, 0, 3);
    repeat (3) drive(0, 4, 1, 0, 1);

    // Backpressure: W=2, consumer stalled for 6 cycles
    repeat (4) drive(1, 2, 1, 0, 1);
    repeat (6) drive(1, 2, 0, 0, 2);
    repeat (10) drive(1, 2, 1, 0, 1);

    // Clear on and off window ends
    drive(1, 2, 1, 1, 7);
    drive(1, 2, 1, 0, 0);
    drive(1, 2, 1, 1, 7);
    repeat (6) drive(1, 2, 1, 0, 1);

    // windowLen = 0 acts as 1: a sample every cycle
    repeat (20) drive(1, 0, 1, 0, 3);

    // Reset mid-run with a pending sample
    repeat (6) drive(1, 3, 0, 0, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset rateDelta", int'(rateDelta), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (12) drive(1, 3, 1, 0, 2);

    // Randomized traffic
    repeat (500) drive($urandom_range(0, 15) != 0, int'($urandom_range(0, 5)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       int'($urandom_range(0, 9)));

    // Drain
    repeat (5) drive(0, 1, 1, 0, 0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
